// File: rtl/alu_out_sel.sv
// alu_out_sel: registered CH-way ALU result selector feeding a two-entry valid/ready skid buffer,
// with zero flag, sticky aux flag and out-of-range select detection.
module alu_out_sel #(
    parameter int N = 4,
    parameter int CH = 4,
    parameter logic [CH-1:0] AUX_MASK = CH'(8),
    localparam int SELW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SELW-1:0] sel,
    input  logic [N-1:0]    in_data [CH-1:0],
    input  logic [CH-1:0]   in_aux,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic            out_aux,
    output logic            out_zero,
    output logic            sticky_aux,
    output logic            sel_err,
    input  logic            clr_flags
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state_q, state_d;
    // beat layout: {data, aux, zero}
    logic [N+1:0] main_q, main_d, skid_q, skid_d, cap;
    logic in_ready_q, in_ready_d, sticky_aux_q, sticky_aux_d, sel_err_q, sel_err_d;
    logic sel_ok, acc, pop, cap_aux;
    logic [SELW-1:0] idx;
    logic [N-1:0] cap_data;

    assign out_valid  = state_q != EMPTY;
    assign in_ready   = in_ready_q;
    assign out_data   = main_q[N+1:2];
    assign out_aux    = main_q[1];
    assign out_zero   = main_q[0];
    assign sticky_aux = sticky_aux_q;
    assign sel_err    = sel_err_q;

    always_comb begin
        sel_ok = {1'b0, sel} < (SELW+1)'(CH);
        idx = sel_ok ? sel : '0;
        cap_data = in_data[idx];
        cap_aux = sel_ok & in_aux[idx] & AUX_MASK[idx];
        cap = {cap_data, cap_aux, cap_data == '0};
        acc = in_valid & in_ready_q;
        pop = out_valid & out_ready;
        state_d = state_q;
        main_d = main_q;
        skid_d = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = ONE;
                    main_d = cap;
                end
            end
            ONE: begin
                if (acc && !pop) begin
                    state_d = FULL;
                    skid_d = cap;
                end else if (acc) begin
                    main_d = cap;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    main_d = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d = state_d != FULL;
        // a set in the same cycle as a clear wins
        sticky_aux_d = (acc & cap_aux) | (sticky_aux_q & ~clr_flags);
        sel_err_d = (acc & ~sel_ok) | (sel_err_q & ~clr_flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q <= (N+2)'(1);
            skid_q <= '0;
            in_ready_q <= 1'b1;
            sticky_aux_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q <= main_d;
            skid_q <= skid_d;
            in_ready_q <= in_ready_d;
            sticky_aux_q <= sticky_aux_d;
            sel_err_q <= sel_err_d;
        end
    end
endmodule

// File: doc/alu_out_sel.md
# alu_out_sel

Registered, parametrised result selector at the ALU output. Picks one of `CH` operation results of width `N` plus its per-channel auxiliary flag (carry/borrow), then presents it downstream through a two-entry valid/ready skid buffer. Adds backpressure, a zero flag, a sticky auxiliary flag and out-of-range select detection. It is the pipelined, channel-generalised successor of the ALU's 4:1 combinational result mux.

## Interface
- `N`, 4: data width of each result channel and of `out_data`.
- `CH`, 4: number of result channels; legal range 2..16.
- `SELW`, `$clog2(CH)`: select width; derived, not overridden.
- `AUX_MASK`, `CH'b1000`: bit i = 1 lets channel i's `in_aux` propagate. Masked channels force aux to 0.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  block can accept a beat; registered.
- `sel`  in  SELW  channel select, sampled on input handshake.
- `in_data`  in  N x CH (unpacked `[N-1:0] in_data [CH-1:0]`)  channel results.
- `in_aux`  in  CH  per-channel auxiliary flag.
- `out_valid`  out  1  downstream beat present.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  N  selected result.
- `out_aux`  out  1  masked aux of the selected channel.
- `out_zero`  out  1  `out_data == 0`, travels with the beat.
- `sticky_aux`  out  1  set once any accepted beat had aux = 1.
- `sel_err`  out  1  sticky; set when `sel >= CH` is accepted.
- `clr_flags`  in  1  synchronous clear of `sticky_aux` and `sel_err`.

## Operation
- Input handshake: a beat is accepted when `in_valid && in_ready`. At acceptance the block captures:
  - data = `in_data[sel]`
  - aux = `in_aux[sel] & AUX_MASK[sel]`
  - zero = (data == 0)
- Out-of-range select (`sel >= CH`, possible only when CH is not a power of 2):
  - data = `in_data[0]`, aux = 0, zero computed on `in_data[0]`.
  - `sel_err` is set.
- Output handshake: the beat is consumed when `out_valid && out_ready`. `out_data`, `out_aux` and `out_zero` come straight from the main register.
- Storage: a main register plus one skid register. FSM states:
  - EMPTY: `out_valid` = 0, `in_ready` = 1.
  - ONE: main register valid, `out_valid` = 1, `in_ready` = 1.
  - FULL: main and skid valid, `out_valid` = 1, `in_ready` = 0.
- Transitions (acc = input accepted, pop = output consumed):
  - EMPTY + acc → ONE; beat goes to main.
  - ONE + acc, no pop → FULL; beat goes to skid.
  - ONE + acc + pop → ONE; new beat goes to main.
  - ONE + pop, no acc → EMPTY.
  - FULL + pop → ONE; skid moves to main. Acc is impossible because `in_ready` = 0.
  - All other cases hold state.
- Beats leave in acceptance order. None are dropped or duplicated.
- `sticky_aux` is set by the aux value of an *accepted input* beat.
- `clr_flags` clears both sticky flags. If a set and a clear happen in the same cycle, the set wins (flag = 1 next cycle).
- `out_*` payload is held stable while `out_valid && !out_ready`.

## Timing
- Reset (async assert, clocked-domain release):
  - `out_valid` = 0, `in_ready` = 1.
  - `out_data` = 0, `out_aux` = 0, `out_zero` = 1.
  - `sticky_aux` = 0, `sel_err` = 0.
  - FSM = EMPTY, skid contents = 0.
- Latency: a beat accepted on edge k appears with `out_valid` = 1 after edge k, visible in cycle k+1, provided the output stage was empty or popping.
- Throughput: 1 beat/cycle while `out_ready` is held at 1.
- `in_ready` is a register output with no combinational path from `out_ready`. It falls on the edge that enters FULL and rises on the edge that leaves FULL.
- Sticky flags update on the same edge as the accepting handshake.
- Reset asserted mid-stream discards all stored beats immediately, without waiting for a clock. After release the block behaves as freshly reset.

## Test plan
- Reset defaults: assert `rst` mid-cycle with FULL state → all outputs take their reset values at once, without a clock edge.
- Streaming, N=4, CH=4: `out_ready` = 1, `sel` cycling 0..3, data 5/A/0/F, `in_aux` = 4'b1111 → outputs one cycle later:
  - data 5/A/0/F
  - `out_aux` 0/0/0/1
  - `out_zero` set on the third beat only.
- Backpressure: `out_ready` = 0 for 3 cycles while `in_valid` = 1 → 2 beats accepted, then `in_ready` = 0. After release, both beats emerge in order with no loss, then `in_ready` returns to 1.
- Out-of-range: CH=3, `sel` = 3, `in_data[0]` = 0x6 → out_data 0x6, out_aux 0, `sel_err` = 1 and held until `clr_flags`.
- Sticky flags:
  - aux = 1 on channel 3 → `sticky_aux` = 1.
  - `clr_flags` pulse with no new aux → 0.
  - `clr_flags` coinciding with an accepted aux = 1 beat → stays 1.
- Parameter sweep: N=8, CH=8, `AUX_MASK` = 8'h81, random traffic with random `out_ready` → scoreboard matches data and aux, order is preserved, and `out_*` is stable during every stall.
